counter_sequencer: RTL and testbench

- Command-driven controller for the 8-bit loadable counter (data_in/q/inc/ld interface).
- Accepts a {start, end} command over a valid/ready handshake and drives the counter's load.
- Then steps the counter once every PRESCALE cycles until q equals end, and reports completion.
- Sits between the control/bus side and one counter instance; the counter's own reset is not driven here.

---
 rtl/counter_sequencer.sv | 129 ++++++++++++
 tb/tb_counter_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - command-driven load/step sequencer for an 8-bit loadable counter
module counter_sequencer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic [WIDTH-1:0] cnt_data,
    output logic             cnt_ld,
    output logic             cnt_inc,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    // A one-bit prescaler is kept even for PRESCALE==1 so the width never collapses to zero.
    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE,
        ST_ABORT
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    prescale_q;
    logic [PW-1:0]    prescale_d;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] end_q;
    logic             cmd_ready_q;
    logic             cnt_ld_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;

    logic at_end;
    logic tick;

    assign at_end = (cnt_q == end_q);
    assign tick   = (prescale_q == PS_LAST);

    // The step strobe must react to abort/pause/cnt_q in the same cycle, so it stays combinational.
    assign cnt_inc = (state_q == ST_RUN) && !abort && !at_end && !pause && tick;

    always_comb begin
        prescale_d = prescale_q;
        if (state_q == ST_LOAD) begin
            prescale_d = '0;
        end else if (state_q == ST_RUN && !abort && !at_end && !pause) begin
            prescale_d = tick ? '0 : prescale_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            prescale_q  <= '0;
            start_q     <= '0;
            end_q       <= '0;
            cmd_ready_q <= 1'b1;
            cnt_ld_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            cnt_ld_q   <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        start_q     <= cmd_start;
                        end_q       <= cmd_end;
                        cnt_ld_q    <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= ST_ABORT;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= ST_ABORT;
                    end else if (at_end) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE, ST_ABORT: begin
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign cnt_data  = start_q;
    assign cnt_ld    = cnt_ld_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - directed self-checking bench for counter_sequencer
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       va, vb, pause, abort;
    logic [7:0] cs, ce;

    logic       rdy_a, ld_a, inc_a, busy_a, done_a, ab_a;
    logic [7:0] data_a;
    logic [7:0] q_a = 8'h00;
    logic       rdy_b, ld_b, inc_b, busy_b, done_b, ab_b;
    logic [7:0] data_b;
    logic [7:0] q_b = 8'h00;

    always #5 clk = ~clk;

    counter_sequencer #(.WIDTH(8), .PRESCALE(4)) u_dut_a (
        .clk(clk), .rst(rst), .cmd_valid(va), .cmd_ready(rdy_a),
        .cmd_start(cs), .cmd_end(ce), .pause(pause), .abort(abort),
        .cnt_q(q_a), .cnt_data(data_a), .cnt_ld(ld_a), .cnt_inc(inc_a),
        .busy(busy_a), .done(done_a), .aborted(ab_a)
    );

    counter_sequencer #(.WIDTH(8), .PRESCALE(1)) u_dut_b (
        .clk(clk), .rst(rst), .cmd_valid(vb), .cmd_ready(rdy_b),
        .cmd_start(cs), .cmd_end(ce), .pause(pause), .abort(abort),
        .cnt_q(q_b), .cnt_data(data_b), .cnt_ld(ld_b), .cnt_inc(inc_b),
        .busy(busy_b), .done(done_b), .aborted(ab_b)
    );

    // Loadable counter models; their own reset is never pulsed.
    always @(posedge clk) begin
        if (ld_a) q_a <= data_a;
        else if (inc_a) q_a <= q_a + 8'd1;
        if (ld_b) q_b <= data_b;
        else if (inc_b) q_b <= q_b + 8'd1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         inc_cyc[$];
    int         ld_n, inc_n, done_n, ab_n, done_at, ab_at, rdy_at, ld_at, viol;
    logic [7:0] ld_val;
    logic [7:0] q_log[64];
    logic [13:0] snap;

    function automatic int inc_k(input int k);
        if (k < inc_cyc.size()) return inc_cyc[k];
        return -1;
    endfunction

    // Cycle 0 presents the command; everything is logged by cycle index relative to it.
    task automatic run(input bit sel, input logic [7:0] s, input logic [7:0] e,
                       input int p_from, input int p_len, input int a_from, input int a_to,
                       input int r_at, input int ncyc);
        logic       r, l, i, b, d, a, prev_i;
        logic [7:0] q, dt;
        inc_cyc.delete();
        ld_n = 0; inc_n = 0; done_n = 0; ab_n = 0; viol = 0;
        done_at = -1; ab_at = -1; rdy_at = -1; ld_at = -1; ld_val = 8'h00;
        snap = '0; prev_i = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            cs    = s;
            ce    = e;
            va    = !sel && (c == 0);
            vb    = sel && (c == 0);
            pause = (c >= p_from) && (c < p_from + p_len);
            abort = (c >= a_from) && (c < a_to);
            rst   = (c != r_at);
            #1;
            if (sel) begin
                r = rdy_b; l = ld_b; i = inc_b; b = busy_b; d = done_b; a = ab_b; q = q_b; dt = data_b;
            end else begin
                r = rdy_a; l = ld_a; i = inc_a; b = busy_a; d = done_a; a = ab_a; q = q_a; dt = data_a;
            end
            if (l) begin ld_n++; ld_at = c; ld_val = dt; end
            if (i) begin
                inc_n++;
                inc_cyc.push_back(c);
                if (pause) viol++;
                if (prev_i && !sel) viol++;
            end
            if (l && i) viol++;
            if (d) begin done_n++; done_at = c; end
            if (a) begin ab_n++; ab_at = c; end
            if (r && c > 0 && rdy_at < 0) rdy_at = c;
            q_log[c] = q;
            if (c == r_at + 1) snap = {r, b, l, i, d, a, dt};
            prev_i = i;
        end
        va = 1'b0; vb = 1'b0; pause = 1'b0; abort = 1'b0; rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; va = 1'b0; vb = 1'b0; pause = 1'b0; abort = 1'b0;
        cs = 8'h00; ce = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", rdy_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_ld_inc", {ld_a, inc_a}, 0);
        check("rst_pulses", {done_a, ab_a}, 0);
        check("rst_data", data_a, 8'h00);
        check("rst_ready_b", rdy_b, 1);
        rst = 1'b1;

        // Basic run
        run(1'b0, 8'd10, 8'd13, 99, 0, 99, 99, 99, 20);
        check("t1_ld_n", ld_n, 1);
        check("t1_ld_at", ld_at, 1);
        check("t1_ld_val", ld_val, 8'd10);
        check("t1_inc_n", inc_n, 3);
        check("t1_inc0", inc_k(0), 5);
        check("t1_inc1", inc_k(1), 9);
        check("t1_inc2", inc_k(2), 13);
        check("t1_q14", q_log[14], 8'd13);
        check("t1_done_at", done_at, 15);
        check("t1_done_n", done_n, 1);
        check("t1_rdy_at", rdy_at, 16);
        check("t1_ab_n", ab_n, 0);
        check("t1_viol", viol, 0);

        // Zero length
        run(1'b0, 8'h55, 8'h55, 99, 0, 99, 99, 99, 6);
        check("t2_ld_n", ld_n, 1);
        check("t2_inc_n", inc_n, 0);
        check("t2_done_at", done_at, 3);
        check("t2_rdy_at", rdy_at, 4);

        // Wrap with PRESCALE=1
        run(1'b1, 8'hFE, 8'h01, 99, 0, 99, 99, 99, 9);
        check("t3_inc_n", inc_n, 3);
        check("t3_inc0", inc_k(0), 2);
        check("t3_inc1", inc_k(1), 3);
        check("t3_inc2", inc_k(2), 4);
        check("t3_q_seq", {q_log[2], q_log[3], q_log[4], q_log[5]}, 32'hFEFF0001);
        check("t3_done_at", done_at, 6);
        check("t3_viol", viol, 0);

        // Pause for 5 cycles mid-count
        run(1'b0, 8'd10, 8'd13, 7, 5, 99, 99, 99, 24);
        check("t4_inc_n", inc_n, 3);
        check("t4_inc0", inc_k(0), 5);
        check("t4_inc1", inc_k(1), 14);
        check("t4_inc2", inc_k(2), 18);
        check("t4_done_at", done_at, 20);
        check("t4_rdy_at", rdy_at, 21);
        check("t4_viol", viol, 0);

        // Abort after one increment, abort then held into IDLE
        run(1'b0, 8'd10, 8'd13, 99, 0, 7, 13, 99, 15);
        check("t5_inc_n", inc_n, 1);
        check("t5_ab_at", ab_at, 8);
        check("t5_ab_n", ab_n, 1);
        check("t5_done_n", done_n, 0);
        check("t5_q_end", q_log[14], 8'd11);
        check("t5_rdy_at", rdy_at, 9);
        check("t5_busy_end", busy_a, 0);

        // Reset mid-run, then a fresh command
        run(1'b0, 8'd10, 8'd13, 99, 0, 99, 99, 7, 12);
        check("t6_snap", snap, {6'b100000, 8'h00});
        check("t6_pulses", done_n + ab_n, 0);
        check("t6_rdy_at", rdy_at, 8);
        run(1'b0, 8'h20, 8'h22, 99, 0, 99, 99, 99, 14);
        check("t6b_inc_n", inc_n, 2);
        check("t6b_inc0", inc_k(0), 5);
        check("t6b_inc1", inc_k(1), 9);
        check("t6b_done_at", done_at, 11);
        check("t6b_q_end", q_log[13], 8'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
